// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem writeback path: source encoding and the
// buffered writeback request carried through the load FIFO.
package fpu_ss_pkg;

    localparam int unsigned FP_FLEN = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_FPU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [4:0]         rd;
        logic [FP_FLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/fpu_ss_wb_fifo.sv
// Small synchronous FIFO of writeback requests used to buffer load responses.
// Push is ignored when full and pop is ignored when empty.
module fpu_ss_wb_fifo
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wb_req_t data_i,
    input  logic    pop_i,
    output wb_req_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// Owns the FP register-file write port: arbitrates buffered loads against FPU
// results with a starvation guard, and steers integer results to the core.
// Define FPU_SS_WB_OUT_REG_EN to register the write-port and scoreboard outputs.
module fpu_ss_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned FLEN           = FP_FLEN,
    parameter int unsigned LOAD_BUF_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            fpu_valid_i,
    output logic            fpu_ready_o,
    input  logic            fpu_rd_is_fp_i,
    input  logic [4:0]      fpu_rd_i,
    input  logic [FLEN-1:0] fpu_data_i,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [4:0]      mem_rd_i,
    input  logic [FLEN-1:0] mem_data_i,
    output logic            fpr_we_o,
    output logic [4:0]      fpr_waddr_o,
    output logic [FLEN-1:0] fpr_wdata_o,
    output logic [1:0]      wb_src_o,
    output logic            int_valid_o,
    input  logic            int_ready_i,
    output logic [4:0]      int_rd_o,
    output logic [31:0]     int_data_o,
    output logic            sb_clr_o,
    output logic [4:0]      sb_clr_addr_o
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic          active;
    logic          fifo_full, fifo_empty, fifo_push;
    wb_req_t       fifo_in, fifo_head;
    logic          l_req, f_req, i_req, starve_hit;
    logic          grant_f, grant_l;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [FLEN-1:0] wr_data;
    wb_src_e       wr_src;

    // Everything is held quiet while reset is asserted so no stale entry can write.
    assign active       = ~rst_i;
    assign mem_ready_o  = active & ~fifo_full;
    assign fifo_push    = mem_valid_i & mem_ready_o;
    assign fifo_in.rd   = mem_rd_i;
    assign fifo_in.data = mem_data_i;

    fpu_ss_wb_fifo #(
        .DEPTH (LOAD_BUF_DEPTH)
    ) u_load_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (grant_l),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign l_req      = active & ~fifo_empty;
    assign f_req      = active & fpu_valid_i & fpu_rd_is_fp_i;
    assign i_req      = active & fpu_valid_i & ~fpu_rd_is_fp_i;
    assign starve_hit = (starve_cnt_q == SW'(STARVE_LIMIT));

    assign int_valid_o = i_req;
    assign int_rd_o    = fpu_rd_i;
    assign int_data_o  = fpu_data_i[31:0];

    always_comb begin
        grant_f      = f_req & (~l_req | starve_hit);
        grant_l      = l_req & ~grant_f;
        starve_cnt_d = starve_cnt_q;
        if (grant_f) begin
            starve_cnt_d = '0;
        end else if (f_req && grant_l && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        wr_en   = grant_f | grant_l;
        wr_addr = '0;
        wr_data = '0;
        wr_src  = WB_NONE;
        if (grant_f) begin
            wr_addr = fpu_rd_i;
            wr_data = fpu_data_i;
            wr_src  = WB_FPU;
        end else if (grant_l) begin
            wr_addr = fifo_head.rd;
            wr_data = fifo_head.data;
            wr_src  = WB_LOAD;
        end

        fpu_ready_o = i_req ? int_ready_i : grant_f;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef FPU_SS_WB_OUT_REG_EN
    logic            fpr_we_q, fpr_we_d;
    logic [4:0]      fpr_waddr_q, fpr_waddr_d;
    logic [FLEN-1:0] fpr_wdata_q, fpr_wdata_d;
    logic [1:0]      wb_src_q, wb_src_d;

    always_comb begin
        fpr_we_d    = wr_en;
        fpr_waddr_d = wr_addr;
        fpr_wdata_d = wr_data;
        wb_src_d    = wr_src;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpr_we_q    <= 1'b0;
            fpr_waddr_q <= '0;
            fpr_wdata_q <= '0;
            wb_src_q    <= WB_NONE;
        end else begin
            fpr_we_q    <= fpr_we_d;
            fpr_waddr_q <= fpr_waddr_d;
            fpr_wdata_q <= fpr_wdata_d;
            wb_src_q    <= wb_src_d;
        end
    end

    assign fpr_we_o      = fpr_we_q;
    assign fpr_waddr_o   = fpr_waddr_q;
    assign fpr_wdata_o   = fpr_wdata_q;
    assign wb_src_o      = wb_src_q;
    assign sb_clr_o      = fpr_we_q;
    assign sb_clr_addr_o = fpr_waddr_q;
`else
    assign fpr_we_o      = wr_en;
    assign fpr_waddr_o   = wr_addr;
    assign fpr_wdata_o   = wr_data;
    assign wb_src_o      = wr_src;
    assign sb_clr_o      = wr_en;
    assign sb_clr_addr_o = wr_addr;
`endif

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed self-checking bench for fpu_ss_wb_arbiter (LOAD_BUF_DEPTH=2, STARVE_LIMIT=4).
// With FPU_SS_WB_OUT_REG_EN defined only the registered-output scenarios run.
module tb_fpu_ss_wb_arbiter;
    import fpu_ss_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fpu_valid_i, fpu_ready_o, fpu_rd_is_fp_i;
    logic [4:0]  fpu_rd_i;
    logic [31:0] fpu_data_i;
    logic        mem_valid_i, mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_data_i;
    logic        fpr_we_o;
    logic [4:0]  fpr_waddr_o;
    logic [31:0] fpr_wdata_o;
    logic [1:0]  wb_src_o;
    logic        int_valid_o, int_ready_i;
    logic [4:0]  int_rd_o;
    logic [31:0] int_data_o;
    logic        sb_clr_o;
    logic [4:0]  sb_clr_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_ss_wb_arbiter #(
        .FLEN           (32),
        .LOAD_BUF_DEPTH (2),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fpu_valid_i    (fpu_valid_i),
        .fpu_ready_o    (fpu_ready_o),
        .fpu_rd_is_fp_i (fpu_rd_is_fp_i),
        .fpu_rd_i       (fpu_rd_i),
        .fpu_data_i     (fpu_data_i),
        .mem_valid_i    (mem_valid_i),
        .mem_ready_o    (mem_ready_o),
        .mem_rd_i       (mem_rd_i),
        .mem_data_i     (mem_data_i),
        .fpr_we_o       (fpr_we_o),
        .fpr_waddr_o    (fpr_waddr_o),
        .fpr_wdata_o    (fpr_wdata_o),
        .wb_src_o       (wb_src_o),
        .int_valid_o    (int_valid_o),
        .int_ready_i    (int_ready_i),
        .int_rd_o       (int_rd_o),
        .int_data_o     (int_data_o),
        .sb_clr_o       (sb_clr_o),
        .sb_clr_addr_o  (sb_clr_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] ld_data(input logic [4:0] rd);
        return 32'hA000_0000 | 32'(rd);
    endfunction

    task automatic expect_wr(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic [1:0] src);
        check({tag, ".we"}, 64'(fpr_we_o), 64'(we));
        check({tag, ".clr"}, 64'(sb_clr_o), 64'(we));
        check({tag, ".src"}, 64'(wb_src_o), 64'(src));
        if (we) begin
            check({tag, ".waddr"}, 64'(fpr_waddr_o), 64'(addr));
            check({tag, ".wdata"}, 64'(fpr_wdata_o), 64'(data));
            check({tag, ".clr_addr"}, 64'(sb_clr_addr_o), 64'(addr));
        end
    endtask

    task automatic idle_inputs();
        fpu_valid_i    = 1'b0;
        fpu_rd_is_fp_i = 1'b0;
        fpu_rd_i       = '0;
        fpu_data_i     = '0;
        mem_valid_i    = 1'b0;
        mem_rd_i       = '0;
        mem_data_i     = '0;
        int_ready_i    = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        mem_valid_i = 1'b1;
        mem_rd_i    = rd;
        mem_data_i  = ld_data(rd);
    endtask

    task automatic drive_fpu(input logic [4:0] rd, input logic [31:0] data);
        fpu_valid_i    = 1'b1;
        fpu_rd_is_fp_i = 1'b1;
        fpu_rd_i       = rd;
        fpu_data_i     = data;
    endtask

    // Streams loads base..base+5 against an FPU result to rd 8; four load grants,
    // then the starvation grant. Leaves base+4 and base+5 buffered (FIFO full).
    task automatic starve_fill(input logic [4:0] base);
        drive_load(base);
        settle();
        expect_wr("sf.prime", 1'b0, '0, '0, WB_NONE);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive_fpu(5'd8, 32'hF0F0_0008);
            drive_load(base + 5'(i));
            settle();
            expect_wr($sformatf("sf.load%0d", i), 1'b1, base + 5'(i - 1),
                      ld_data(base + 5'(i - 1)), WB_LOAD);
            check($sformatf("sf.fpu_rdy%0d", i), 64'(fpu_ready_o), 64'd0);
            tick();
        end
        drive_load(base + 5'd5);
        settle();
        expect_wr("sf.starve", 1'b1, 5'd8, 32'hF0F0_0008, WB_FPU);
        check("sf.starve.fpu_rdy", 64'(fpu_ready_o), 64'd1);
        check("sf.starve.mem_rdy", 64'(mem_ready_o), 64'd1);
        tick();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset();
        expect_wr("reset", 1'b0, '0, '0, WB_NONE);
        check("reset.mem_rdy", 64'(mem_ready_o), 64'd1);
        check("reset.int_valid", 64'(int_valid_o), 64'd0);
        check("reset.fpu_rdy", 64'(fpu_ready_o), 64'd0);
        tick();

`ifdef FPU_SS_WB_OUT_REG_EN
        // FPU-only result: handshake now, write one cycle later
        drive_fpu(5'd3, 32'h4000_0000);
        settle();
        check("reg.fpu_rdy", 64'(fpu_ready_o), 64'd1);
        expect_wr("reg.fpu.c0", 1'b0, '0, '0, WB_NONE);
        tick();
        idle_inputs();
        settle();
        expect_wr("reg.fpu.c1", 1'b1, 5'd3, 32'h4000_0000, WB_FPU);
        tick();
        settle();
        expect_wr("reg.fpu.c2", 1'b0, '0, '0, WB_NONE);

        // Load: buffered one cycle, registered one more
        drive_load(5'd5);
        settle();
        tick();
        idle_inputs();
        settle();
        expect_wr("reg.ld.c1", 1'b0, '0, '0, WB_NONE);
        tick();
        expect_wr("reg.ld.c2", 1'b1, 5'd5, ld_data(5'd5), WB_LOAD);
        tick();
        expect_wr("reg.ld.c3", 1'b0, '0, '0, WB_NONE);
`else
        // Idle to load only
        mem_valid_i = 1'b1;
        mem_rd_i    = 5'd5;
        mem_data_i  = 32'h3F80_0000;
        settle();
        check("ld.mem_rdy", 64'(mem_ready_o), 64'd1);
        expect_wr("ld.c0", 1'b0, '0, '0, WB_NONE);
        tick();
        idle_inputs();
        settle();
        expect_wr("ld.c1", 1'b1, 5'd5, 32'h3F80_0000, WB_LOAD);
        tick();
        settle();
        expect_wr("ld.c2", 1'b0, '0, '0, WB_NONE);

        // Integer result with back-pressure for two cycles
        fpu_valid_i    = 1'b1;
        fpu_rd_is_fp_i = 1'b0;
        fpu_rd_i       = 5'd9;
        fpu_data_i     = 32'h0000_0001;
        for (int c = 0; c < 3; c++) begin
            int_ready_i = (c == 2);
            settle();
            check($sformatf("int.valid%0d", c), 64'(int_valid_o), 64'd1);
            check($sformatf("int.fpu_rdy%0d", c), 64'(fpu_ready_o), (c == 2) ? 64'd1 : 64'd0);
            check($sformatf("int.we%0d", c), 64'(fpr_we_o), 64'd0);
            tick();
        end
        check("int.rd", 64'(int_rd_o), 64'd9);
        check("int.data", 64'(int_data_o), 64'd1);
        idle_inputs();
        settle();
        check("int.valid_end", 64'(int_valid_o), 64'd0);

        // Starvation: four load grants then the FPU, then drain in order
        starve_fill(5'd10);
        idle_inputs();
        settle();
        expect_wr("st.drain0", 1'b1, 5'd14, ld_data(5'd14), WB_LOAD);
        tick();
        expect_wr("st.drain1", 1'b1, 5'd15, ld_data(5'd15), WB_LOAD);
        tick();
        expect_wr("st.idle", 1'b0, '0, '0, WB_NONE);

        // FIFO full: third load is refused while full even though the head pops
        starve_fill(5'd20);
        drive_fpu(5'd9, 32'hF0F0_0009);
        drive_load(5'd26);
        settle();
        check("full.mem_rdy", 64'(mem_ready_o), 64'd0);
        expect_wr("full.c6", 1'b1, 5'd24, ld_data(5'd24), WB_LOAD);
        check("full.fpu_rdy6", 64'(fpu_ready_o), 64'd0);
        tick();
        check("full.mem_rdy7", 64'(mem_ready_o), 64'd1);
        expect_wr("full.c7", 1'b1, 5'd25, ld_data(5'd25), WB_LOAD);
        tick();
        mem_valid_i = 1'b0;
        settle();
        expect_wr("full.c8", 1'b1, 5'd26, ld_data(5'd26), WB_LOAD);
        check("full.fpu_rdy8", 64'(fpu_ready_o), 64'd0);
        tick();
        expect_wr("full.c9", 1'b1, 5'd9, 32'hF0F0_0009, WB_FPU);
        check("full.fpu_rdy9", 64'(fpu_ready_o), 64'd1);
        tick();
        idle_inputs();
        settle();
        expect_wr("full.idle", 1'b0, '0, '0, WB_NONE);

        // Reset with two loads buffered: nothing stale is written afterwards
        starve_fill(5'd2);
        idle_inputs();
        rst_i = 1'b1;
        settle();
        check("rst.we_during", 64'(fpr_we_o), 64'd0);
        tick();
        rst_i = 1'b0;
        settle();
        expect_wr("rst.after0", 1'b0, '0, '0, WB_NONE);
        check("rst.mem_rdy", 64'(mem_ready_o), 64'd1);
        tick();
        expect_wr("rst.after1", 1'b0, '0, '0, WB_NONE);

        // Counter cleared by reset: load wins the first contested cycle
        drive_load(5'd30);
        settle();
        tick();
        mem_valid_i = 1'b0;
        drive_fpu(5'd11, 32'hF0F0_000B);
        settle();
        expect_wr("post.load", 1'b1, 5'd30, ld_data(5'd30), WB_LOAD);
        check("post.fpu_rdy0", 64'(fpu_ready_o), 64'd0);
        tick();
        expect_wr("post.fpu", 1'b1, 5'd11, 32'hF0F0_000B, WB_FPU);
        check("post.fpu_rdy1", 64'(fpu_ready_o), 64'd1);
        tick();
        idle_inputs();
        settle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
